// File: rtl/commit_monitor_pkg.sv
// Shared types, default parameters and helpers for the commit_monitor run
// monitor and its retire trace FIFO.
package commit_monitor_pkg;

    // Run status as presented on the debug bus
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        DONE    = 3'd2,
        TIMEOUT = 3'd3,
        STALLED = 3'd4
    } monitor_state_t;

    // Default run limits and trace storage
    localparam int DEFAULT_MAX_CYCLES  = 6000;
    localparam int DEFAULT_STALL_LIMIT = 256;
    localparam int DEFAULT_TRACE_DEPTH = 8;

    // Number of set bits in a retire strobe of up to eight lanes
    function automatic logic [3:0] popcount(input logic [7:0] bits);
        logic [3:0] total;
        total = 4'd0;
        for (int i = 0; i < 8; i++) begin
            total = total + {3'b000, bits[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/commit_monitor_retire_trace_fifo.sv
// First-word-fall-through FIFO for retire trace entries. The head entry is
// presented whenever the FIFO is non-empty; a push while full is accepted
// only when a pop happens in the same cycle. A synchronous clear empties the
// FIFO when a new run starts.
module commit_monitor_retire_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == (AW + 1)'(DEPTH));
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping, cleared on reset or run restart
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observed through a valid head
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/commit_monitor.sv
// Run monitor for the retire stage: counts RUN cycles and retired
// instructions, detects completion, enforces a cycle budget and a no-retire
// stall limit, and optionally records retire addresses in a trace FIFO.
// Define COMMIT_MONITOR_TRACE_EN to build the trace FIFO; otherwise the trace
// outputs are tied to zero and trace_ready is ignored.
module commit_monitor
    import commit_monitor_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int RETIRE_WIDTH = 2,
    parameter int CNT_WIDTH    = 32,
    parameter int MAX_CYCLES   = DEFAULT_MAX_CYCLES,
    parameter int STALL_LIMIT  = DEFAULT_STALL_LIMIT,
    parameter int TRACE_DEPTH  = DEFAULT_TRACE_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [RETIRE_WIDTH-1:0]            retire_valid,
    input  logic [RETIRE_WIDTH*ADDR_WIDTH-1:0] retire_addr,
    input  logic                               done_in,
    output monitor_state_t                     state,
    output logic [CNT_WIDTH-1:0]               cycle_cnt,
    output logic [CNT_WIDTH-1:0]               retired_cnt,
    output logic                               trace_valid,
    input  logic                               trace_ready,
    output logic [RETIRE_WIDTH-1:0]            trace_mask,
    output logic [RETIRE_WIDTH*ADDR_WIDTH-1:0] trace_addr,
    output logic [CNT_WIDTH-1:0]               trace_cycle,
    output logic                               trace_overflow
);

    logic                 in_run;
    logic                 start_accept;
    logic                 any_retire;
    logic [3:0]           lane_count;
    logic [CNT_WIDTH+3:0] retired_sum;
    logic [CNT_WIDTH-1:0] retired_next;
    logic [CNT_WIDTH-1:0] cycle_next;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] stall_next;
    logic                 hit_timeout;
    logic                 hit_stall;

    assign in_run       = (state == RUN);
    assign start_accept = start && !in_run;
    assign any_retire   = |retire_valid;
    assign lane_count   = popcount(8'(retire_valid));

    // Saturating next values; the wide sum catches carries past all-ones
    assign retired_sum  = {4'b0000, retired_cnt} + {{CNT_WIDTH{1'b0}}, lane_count};
    assign retired_next = (|retired_sum[CNT_WIDTH+3:CNT_WIDTH]) ? '1 : retired_sum[CNT_WIDTH-1:0];
    assign cycle_next   = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_WIDTH'(1);
    assign stall_next   = (&stall_cnt) ? stall_cnt : stall_cnt + CNT_WIDTH'(1);

    // Limits are compared at 64 bits so a budget larger than the counter
    // range simply never fires instead of aliasing onto a truncated value
    assign hit_timeout  = (64'(cycle_cnt) == 64'(MAX_CYCLES - 1));
    assign hit_stall    = (STALL_LIMIT != 0) && !any_retire &&
                          (64'(stall_cnt) == 64'(STALL_LIMIT - 1));

    // Run-control FSM with its cycle, retire and stall counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    cycle_cnt   <= cycle_next;
                    retired_cnt <= retired_next;
                    stall_cnt   <= any_retire ? '0 : stall_next;
                    if (done_in) begin
                        state <= DONE;
                    end else if (hit_timeout) begin
                        state <= TIMEOUT;
                    end else if (hit_stall) begin
                        state <= STALLED;
                    end
                end
                IDLE, DONE, TIMEOUT, STALLED: begin
                    if (start) begin
                        state       <= RUN;
                        cycle_cnt   <= '0;
                        retired_cnt <= '0;
                        stall_cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef COMMIT_MONITOR_TRACE_EN

    localparam int ENTRY_W = RETIRE_WIDTH * (ADDR_WIDTH + 1) + CNT_WIDTH;

    logic [RETIRE_WIDTH*ADDR_WIDTH-1:0] masked_addr;
    logic [ENTRY_W-1:0]                 entry;
    logic [ENTRY_W-1:0]                 head;
    logic                               fifo_full;
    logic                               fifo_empty;
    logic                               push_req;
    logic                               pop_req;
    logic                               push_dropped;
    logic                               overflow_q;

    // Zero the addresses of lanes that did not retire this cycle
    always_comb begin
        masked_addr = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (retire_valid[i]) begin
                masked_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = retire_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign entry        = {retire_valid, masked_addr, cycle_cnt};
    assign push_req     = in_run && any_retire;
    assign pop_req      = trace_ready && !fifo_empty;
    assign push_dropped = push_req && fifo_full && !pop_req;

    commit_monitor_retire_trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_accept),
        .push      (push_req),
        .pop       (trace_ready),
        .push_data (entry),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sticky drop flag, cleared only by reset or a new run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (start_accept) begin
            overflow_q <= 1'b0;
        end else if (push_dropped) begin
            overflow_q <= 1'b1;
        end
    end

    // Head fields read zero while empty so reset leaves every output at zero
    assign trace_valid                           = !fifo_empty;
    assign {trace_mask, trace_addr, trace_cycle} = fifo_empty ? '0 : head;
    assign trace_overflow                        = overflow_q;

`else

    logic unused_trace_ready;
    assign unused_trace_ready = trace_ready;

    assign trace_valid    = 1'b0;
    assign trace_mask     = '0;
    assign trace_addr     = '0;
    assign trace_cycle    = '0;
    assign trace_overflow = 1'b0;

`endif

endmodule

// File: tb/tb_commit_monitor.sv
// Scoreboard bench for commit_monitor. Stimulus pushes expected status and
// expected trace entries into queues; a monitor on the falling edge pops and
// compares them. A second instance with a 4-bit counter covers saturation.
module tb_commit_monitor;
    import commit_monitor_pkg::*;

    localparam int AW  = 8;
    localparam int RW  = 2;
    localparam int CW  = 32;
    localparam int CW2 = 4;

`ifdef COMMIT_MONITOR_TRACE_EN
    localparam logic TRACE_EN = 1'b1;
`else
    localparam logic TRACE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic             start = 1'b0;
    logic             done_in = 1'b0;
    logic             trace_ready = 1'b1;
    logic [RW-1:0]    retire_valid = '0;
    logic [RW*AW-1:0] retire_addr = '0;
    monitor_state_t   state;
    logic [CW-1:0]    cycle_cnt;
    logic [CW-1:0]    retired_cnt;
    logic             trace_valid;
    logic [RW-1:0]    trace_mask;
    logic [RW*AW-1:0] trace_addr;
    logic [CW-1:0]    trace_cycle;
    logic             trace_overflow;

    logic             start2 = 1'b0;
    logic             done2 = 1'b0;
    logic [RW-1:0]    retire_valid2 = '0;
    monitor_state_t   state2;
    logic [CW2-1:0]   cycle_cnt2;
    logic [CW2-1:0]   retired_cnt2;
    logic             trace_valid2;
    logic [RW-1:0]    trace_mask2;
    logic [RW*AW-1:0] trace_addr2;
    logic [CW2-1:0]   trace_cycle2;
    logic             trace_overflow2;

    commit_monitor #(
        .ADDR_WIDTH   (AW),
        .RETIRE_WIDTH (RW),
        .CNT_WIDTH    (CW),
        .MAX_CYCLES   (50),
        .STALL_LIMIT  (8),
        .TRACE_DEPTH  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .retire_valid   (retire_valid),
        .retire_addr    (retire_addr),
        .done_in        (done_in),
        .state          (state),
        .cycle_cnt      (cycle_cnt),
        .retired_cnt    (retired_cnt),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_mask     (trace_mask),
        .trace_addr     (trace_addr),
        .trace_cycle    (trace_cycle),
        .trace_overflow (trace_overflow)
    );

    commit_monitor #(
        .ADDR_WIDTH   (AW),
        .RETIRE_WIDTH (RW),
        .CNT_WIDTH    (CW2),
        .MAX_CYCLES   (6000),
        .STALL_LIMIT  (0),
        .TRACE_DEPTH  (4)
    ) dut_sat (
        .clk            (clk),
        .rst            (rst),
        .start          (start2),
        .retire_valid   (retire_valid2),
        .retire_addr    (retire_addr),
        .done_in        (done2),
        .state          (state2),
        .cycle_cnt      (cycle_cnt2),
        .retired_cnt    (retired_cnt2),
        .trace_valid    (trace_valid2),
        .trace_ready    (1'b1),
        .trace_mask     (trace_mask2),
        .trace_addr     (trace_addr2),
        .trace_cycle    (trace_cycle2),
        .trace_overflow (trace_overflow2)
    );

    typedef struct {
        string          name;
        bit             sel;
        monitor_state_t st;
        logic [CW-1:0]  cyc;
        logic [CW-1:0]  ret;
        logic           ovf;
        bit             tv_care;
        logic           tv;
    } status_t;

    typedef struct {
        logic [RW-1:0]    mask;
        logic [RW*AW-1:0] addr;
        logic [CW-1:0]    cyc;
    } trace_t;

    status_t status_q[$];
    trace_t  trace_q[$];
    int      checks = 0;
    int      errors = 0;

    function automatic void compare_value(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic void compare_status(input status_t s);
        if (s.sel == 1'b0) begin
            compare_value({s.name, ".state"}, 64'(state), 64'(s.st));
            compare_value({s.name, ".cycle_cnt"}, 64'(cycle_cnt), 64'(s.cyc));
            compare_value({s.name, ".retired_cnt"}, 64'(retired_cnt), 64'(s.ret));
            compare_value({s.name, ".trace_overflow"}, 64'(trace_overflow), 64'(s.ovf));
            if (s.tv_care) begin
                compare_value({s.name, ".trace_valid"}, 64'(trace_valid), 64'(s.tv));
            end
`ifndef COMMIT_MONITOR_TRACE_EN
            compare_value({s.name, ".trace_tied"},
                          64'({trace_valid, trace_mask, trace_addr, trace_cycle, trace_overflow}), 64'd0);
`endif
        end else begin
            compare_value({s.name, ".state"}, 64'(state2), 64'(s.st));
            compare_value({s.name, ".cycle_cnt"}, 64'(cycle_cnt2), 64'(s.cyc));
            compare_value({s.name, ".retired_cnt"}, 64'(retired_cnt2), 64'(s.ret));
        end
    endfunction

    // Monitor: consume pending status expectations and every trace pop
    always @(negedge clk) begin : monitor
        status_t cur;
        trace_t  exp_t;
        while (status_q.size() != 0) begin
            cur = status_q.pop_front();
            compare_status(cur);
        end
        if (trace_valid && trace_ready) begin
            if (trace_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL trace_unexpected actual=mask %0h addr %0h cycle %0d required=no entry",
                         trace_mask, trace_addr, trace_cycle);
            end else begin
                exp_t = trace_q.pop_front();
                compare_value("trace.mask", 64'(trace_mask), 64'(exp_t.mask));
                compare_value("trace.addr", 64'(trace_addr), 64'(exp_t.addr));
                compare_value("trace.cycle", 64'(trace_cycle), 64'(exp_t.cyc));
            end
        end
    end

    task automatic applyStimulus(input bit sel, input logic st, input logic [RW-1:0] rv,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic dn, input logic rdy);
        @(posedge clk);
        #2;
        retire_addr = {a1, a0};
        if (sel == 1'b0) begin
            start         = st;
            retire_valid  = rv;
            done_in       = dn;
            trace_ready   = rdy;
            start2        = 1'b0;
            retire_valid2 = '0;
            done2         = 1'b0;
        end else begin
            start         = 1'b0;
            retire_valid  = '0;
            done_in       = 1'b0;
            trace_ready   = 1'b1;
            start2        = st;
            retire_valid2 = rv;
            done2         = dn;
        end
    endtask

    task automatic checkOutput(input string name, input bit sel, input monitor_state_t st,
                               input logic [CW-1:0] cyc, input logic [CW-1:0] ret,
                               input logic ovf, input bit tv_care, input logic tv);
        status_t s;
        s.name    = name;
        s.sel     = sel;
        s.st      = st;
        s.cyc     = cyc;
        s.ret     = ret;
        s.ovf     = ovf;
        s.tv_care = tv_care;
        s.tv      = tv;
        status_q.push_back(s);
    endtask

    function automatic void push_trace(input logic [RW-1:0] m, input logic [AW-1:0] a1,
                                       input logic [AW-1:0] a0, input int cyc);
        trace_t t;
        t.mask = m;
        t.addr = {a1, a0};
        t.cyc  = CW'(cyc);
        if (TRACE_EN) begin
            trace_q.push_back(t);
        end
    endfunction

    logic [RW-1:0] mask_tab [6];

    initial begin : stimulus
        mask_tab = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};

        checkOutput("reset", 1'b0, IDLE, 0, 0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Two lanes retiring for ten cycles, then completion
        applyStimulus(0, 1, 2'b00, 8'h00, 8'h00, 0, 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 2'b11, 8'(16 + i), 8'(32 + i), 0, 1);
            push_trace(2'b11, 8'(32 + i), 8'(16 + i), i);
        end
        applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 1, 1);
        applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 1);
        checkOutput("t1_done", 0, DONE, 11, 20, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(0, 0, 2'b11, 8'h55, 8'h66, 1, 1);
        applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 1);
        checkOutput("t1_hold", 0, DONE, 11, 20, 1'b0, 1'b1, 1'b0);

        // Lane 0 retires every fourth cycle until the budget runs out
        applyStimulus(0, 1, 2'b00, 8'h00, 8'h00, 0, 1);
        for (int k = 0; k < 49; k++) begin
            applyStimulus(0, (k == 20), (k % 4 == 0) ? 2'b01 : 2'b00, 8'(64 + k), 8'hFF, 0, 1);
            if (k % 4 == 0) begin
                push_trace(2'b01, 8'h00, 8'(64 + k), k);
            end
        end
        applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 1);
        checkOutput("t2_pre_timeout", 0, RUN, 49, 13, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 1);
        checkOutput("t2_timeout", 0, TIMEOUT, 50, 13, 1'b0, 1'b0, 1'b0);

        // Lane 1 retires three times, then the core goes quiet
        applyStimulus(0, 1, 2'b00, 8'h00, 8'h00, 0, 1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, (k < 3) ? 2'b10 : 2'b00, 8'hAA, 8'(k + 1), 0, 1);
            if (k < 3) begin
                push_trace(2'b10, 8'(k + 1), 8'h00, k);
            end
        end
        applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 1);
        checkOutput("t3_pre_stall", 0, RUN, 10, 3, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 1);
        checkOutput("t3_stalled", 0, STALLED, 11, 3, 1'b0, 1'b0, 1'b0);

        // Completion and timeout in the same cycle
        applyStimulus(0, 1, 2'b00, 8'h00, 8'h00, 0, 1);
        for (int k = 0; k < 50; k++) begin
            applyStimulus(0, 0, 2'b11, 8'(k), 8'(100 + k), (k == 49), 1);
            push_trace(2'b11, 8'(100 + k), 8'(k), k);
        end
        applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 1);
        checkOutput("t4_done_wins", 0, DONE, 50, 100, 1'b0, 1'b0, 1'b0);

        // Six retires with the consumer stalled: four kept, two dropped
        applyStimulus(0, 1, 2'b00, 8'h00, 8'h00, 0, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, mask_tab[k], 8'(8'hC0 + k), 8'(8'hD0 + k), 0, 0);
        end
        push_trace(2'b01, 8'h00, 8'hC0, 0);
        push_trace(2'b10, 8'hD1, 8'h00, 1);
        push_trace(2'b11, 8'hD2, 8'hC2, 2);
        push_trace(2'b01, 8'h00, 8'hC3, 3);
        applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 1, 0);
        applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
        checkOutput("t5_overflow", 0, DONE, 7, 8, TRACE_EN, 1'b1, TRACE_EN);
        repeat (6) applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 1);
        checkOutput("t5_drained", 0, DONE, 7, 8, TRACE_EN, 1'b1, 1'b0);

        // Fill to four, then push and pop together while full
        applyStimulus(0, 1, 2'b00, 8'h00, 8'h00, 0, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 2'b11, 8'(8'hE0 + k), 8'(8'hF0 + k), 0, (k == 4));
            push_trace(2'b11, 8'(8'hF0 + k), 8'(8'hE0 + k), k);
        end
        applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 1, 0);
        applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
        checkOutput("t6_full_pushpop", 0, DONE, 6, 10, 1'b0, 1'b1, TRACE_EN);
        repeat (6) applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 1);
        checkOutput("t6_drained", 0, DONE, 6, 10, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a run with entries still queued
        applyStimulus(0, 1, 2'b00, 8'h00, 8'h00, 0, 0);
        applyStimulus(0, 0, 2'b11, 8'h11, 8'h22, 0, 0);
        applyStimulus(0, 0, 2'b11, 8'h33, 8'h44, 0, 0);
        applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
        checkOutput("t7_pre_reset", 0, RUN, 2, 4, 1'b0, 1'b1, TRACE_EN);
        @(negedge clk);
        #1 rst = 1'b1;
        checkOutput("t7_reset", 0, IDLE, 0, 0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 1);
        checkOutput("t7_after_reset", 0, IDLE, 0, 0, 1'b0, 1'b1, 1'b0);

        // Four-bit counters saturate; stall check disabled on this instance
        applyStimulus(1, 1, 2'b00, 8'h00, 8'h00, 0, 1);
        for (int k = 0; k < 28; k++) begin
            applyStimulus(1, 0, (k < 8) ? 2'b11 : 2'b00, 8'h01, 8'h02, 0, 1);
        end
        applyStimulus(1, 0, 2'b00, 8'h00, 8'h00, 1, 1);
        checkOutput("t8_sat_run", 1, RUN, 15, 15, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 0, 2'b00, 8'h00, 8'h00, 0, 1);
        checkOutput("t8_sat_done", 1, DONE, 15, 15, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        compare_value("trace_queue_drained", 64'(trace_q.size()), 64'd0);
        compare_value("status_queue_drained", 64'(status_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog actual=still running required=finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
